// File: rtl/bus_dev_pkg.sv
// Shared definitions for the bus device port: address field layout,
// broadcast address and saturating event-counter arithmetic.
package bus_dev_pkg;

    localparam int ID_W      = 8;
    localparam int PKT_W_MAX = 256;
    localparam int CNT_W     = 16;

    localparam logic [ID_W-1:0] BROADCAST = 8'hFF;

    // Destination ID lives in the top ID_W bits of a pkt_w-bit packet.
    // The packet is passed zero-extended so one function serves any width.
    function automatic logic [ID_W-1:0] dest_of(input logic [PKT_W_MAX-1:0] pkt,
                                                input int                   pkt_w);
        return ID_W'(pkt >> (pkt_w - ID_W));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc16(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/bus_device_port_fifo.sv
// First-word-fall-through synchronous FIFO; a write into a full FIFO is
// accepted when a read retires the head in the same cycle.
module sync_fifo_fwft #(
    parameter int width = 32,
    parameter int depth = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr,
    input  logic [width-1:0]       wdata,
    input  logic                   rd,
    output logic [width-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(depth):0] cnt
);

    localparam int AW = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full  = (cnt == (AW+1)'(depth));
    assign empty = (cnt == '0);
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || do_rd);

    // Head is read straight from storage so data is visible the cycle after the write.
    assign rdata = empty ? '0 : mem[rd_ptr];

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: storage is not reset; contents are unreachable until written because pointers and count are.
    always_ff @(posedge clk) begin
        if (!reset && do_wr) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/bus_device_port.sv
// Device endpoint on the shared bus: TX queue toward the bus, address-filtered
// RX queue toward the host, plus drop/overflow statistics and a pop-error flag.
module bus_device_port
    import bus_dev_pkg::*;
#(
    parameter int              pckg_sz   = 32,
    parameter int              depth     = 16,
    parameter logic [ID_W-1:0] id        = 8'h00,
    parameter logic [ID_W-1:0] broadcast = BROADCAST
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tx_wr,
    input  logic [pckg_sz-1:0]     tx_data,
    output logic                   tx_full,
    output logic                   pndng,
    output logic [pckg_sz-1:0]     D_pop,
    input  logic                   pop,
    input  logic                   push,
    input  logic [pckg_sz-1:0]     D_push,
    input  logic                   rx_rd,
    output logic [pckg_sz-1:0]     rx_data,
    output logic                   rx_empty,
    output logic [$clog2(depth):0] tx_cnt,
    output logic [$clog2(depth):0] rx_cnt,
    output logic [CNT_W-1:0]       drop_cnt,
    output logic [CNT_W-1:0]       ovf_cnt,
    output logic                   err_pop
);

    logic [ID_W-1:0] dest;
    logic            id_match;
    logic            tx_empty;
    logic            rx_full;

    assign dest     = dest_of(PKT_W_MAX'(D_push), pckg_sz);
    assign id_match = (dest == id) || (dest == broadcast);
    assign pndng    = !tx_empty;

    sync_fifo_fwft #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (tx_wr),
        .wdata (tx_data),
        .rd    (pop),
        .rdata (D_pop),
        .full  (tx_full),
        .empty (tx_empty),
        .cnt   (tx_cnt)
    );

    sync_fifo_fwft #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (push && id_match),
        .wdata (D_push),
        .rd    (rx_rd),
        .rdata (rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .cnt   (rx_cnt)
    );

    // A push lands in at most one bucket: filtered out, or matched but no room.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
            ovf_cnt  <= '0;
            err_pop  <= 1'b0;
        end else begin
            if (push && !id_match)                    drop_cnt <= sat_inc16(drop_cnt);
            if (push && id_match && rx_full && !rx_rd) ovf_cnt <= sat_inc16(ovf_cnt);
            err_pop <= pop && tx_empty;
        end
    end

endmodule

// File: tb/tb_bus_device_port.sv
// Scoreboarded bench for bus_device_port: a queue-based reference model
// produces expectations, an independent monitor compares DUT outputs.
module tb_bus_device_port;

    localparam int          W     = 32;
    localparam int          DEPTH = 16;
    localparam int          CW    = $clog2(DEPTH) + 1;
    localparam logic [7:0]  ID    = 8'h02;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tx_wr = 1'b0;
    logic [W-1:0]  tx_data = '0;
    logic          tx_full;
    logic          pndng;
    logic [W-1:0]  D_pop;
    logic          pop = 1'b0;
    logic          push = 1'b0;
    logic [W-1:0]  D_push = '0;
    logic          rx_rd = 1'b0;
    logic [W-1:0]  rx_data;
    logic          rx_empty;
    logic [CW-1:0] tx_cnt;
    logic [CW-1:0] rx_cnt;
    logic [15:0]   drop_cnt;
    logic [15:0]   ovf_cnt;
    logic          err_pop;

    bus_device_port #(.pckg_sz(W), .depth(DEPTH), .id(ID), .broadcast(8'hFF)) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_wr    (tx_wr),
        .tx_data  (tx_data),
        .tx_full  (tx_full),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .rx_rd    (rx_rd),
        .rx_data  (rx_data),
        .rx_empty (rx_empty),
        .tx_cnt   (tx_cnt),
        .rx_cnt   (rx_cnt),
        .drop_cnt (drop_cnt),
        .ovf_cnt  (ovf_cnt),
        .err_pop  (err_pop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] tx_cnt;
        logic [CW-1:0] rx_cnt;
        logic          pndng;
        logic          tx_full;
        logic          rx_empty;
        logic          err_pop;
        logic [15:0]   drop;
        logic [15:0]   ovf;
    } state_t;

    // Reference model: plain queues plus counters.
    logic [W-1:0] tx_m[$];
    logic [W-1:0] rx_m[$];
    logic [15:0]  drop_m = '0;
    logic [15:0]  ovf_m = '0;
    logic         err_m = 1'b0;
    bit           model_valid = 1'b0;

    // Scoreboard queues filled by the driver, drained by the monitor.
    logic [W-1:0] pop_exp[$];
    logic [W-1:0] rd_exp[$];
    state_t       state_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic w, input logic [W-1:0] wd, input logic p,
                        input logic ps, input logic [W-1:0] pd, input logic r,
                        input logic rst);
        bit     pop_ok, wr_ok, rd_ok, acc;
        state_t s;
        @(negedge clk);
        tx_wr = w; tx_data = wd; pop = p; push = ps; D_push = pd; rx_rd = r; reset = rst;
        if (model_valid) begin
            s.tx_cnt   = CW'(tx_m.size());
            s.rx_cnt   = CW'(rx_m.size());
            s.pndng    = (tx_m.size() != 0);
            s.tx_full  = (tx_m.size() == DEPTH);
            s.rx_empty = (rx_m.size() == 0);
            s.err_pop  = err_m;
            s.drop     = drop_m;
            s.ovf      = ovf_m;
            state_q.push_back(s);
        end
        if (rst) begin
            tx_m.delete();
            rx_m.delete();
            drop_m = '0;
            ovf_m = '0;
            err_m = 1'b0;
            model_valid = 1'b1;
        end else begin
            pop_ok = p && (tx_m.size() != 0);
            wr_ok  = w && ((tx_m.size() < DEPTH) || pop_ok);
            err_m  = p && (tx_m.size() == 0);
            if (pop_ok) pop_exp.push_back(tx_m.pop_front());
            if (wr_ok) tx_m.push_back(wd);
            rd_ok = r && (rx_m.size() != 0);
            acc = 1'b0;
            if (ps) begin
                if (pd[31:24] != ID && pd[31:24] != 8'hFF) begin
                    if (drop_m != 16'hFFFF) drop_m = drop_m + 16'd1;
                end else if (rx_m.size() < DEPTH || rd_ok) begin
                    acc = 1'b1;
                end else if (ovf_m != 16'hFFFF) begin
                    ovf_m = ovf_m + 16'd1;
                end
            end
            if (rd_ok) rd_exp.push_back(rx_m.pop_front());
            if (acc) rx_m.push_back(pd);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, '0, 0, 0);
    endtask

    // Monitor: samples mid-cycle, well clear of the rising edge.
    initial begin
        state_t s;
        forever begin
            @(negedge clk);
            #2;
            if (state_q.size() != 0) begin
                s = state_q.pop_front();
                check("tx_cnt",   32'(tx_cnt),   32'(s.tx_cnt));
                check("rx_cnt",   32'(rx_cnt),   32'(s.rx_cnt));
                check("pndng",    32'(pndng),    32'(s.pndng));
                check("tx_full",  32'(tx_full),  32'(s.tx_full));
                check("rx_empty", 32'(rx_empty), 32'(s.rx_empty));
                check("err_pop",  32'(err_pop),  32'(s.err_pop));
                check("drop_cnt", 32'(drop_cnt), 32'(s.drop));
                check("ovf_cnt",  32'(ovf_cnt),  32'(s.ovf));
                if (!s.pndng)   check("d_pop_idle",   D_pop,   '0);
                if (s.rx_empty) check("rx_data_idle", rx_data, '0);
            end
            if (!reset && pop && pndng) begin
                if (pop_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pop_unexpected: got %0h expected no pop data", D_pop);
                end else check("d_pop", D_pop, pop_exp.pop_front());
            end
            if (!reset && rx_rd && !rx_empty) begin
                if (rd_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected: got %0h expected no read data", rx_data);
                end else check("rx_data", rx_data, rd_exp.pop_front());
            end
        end
    end

    initial begin
        int pw, pp, ps, pr;
        logic [7:0] d;
        step(0, '0, 0, 0, '0, 0, 1);
        step(0, '0, 0, 0, '0, 0, 1);
        idle(1);
        #1;
        check("rst_pndng",    32'(pndng),    0);
        check("rst_rx_empty", 32'(rx_empty), 1);
        check("rst_tx_full",  32'(tx_full),  0);

        // TX: three writes then three back-to-back pops.
        step(1, 32'h01AA0001, 0, 0, '0, 0, 0);
        #1 check("pndng_after_1st_wr", 32'(pndng), 1);
        step(1, 32'h01AA0002, 0, 0, '0, 0, 0);
        step(1, 32'h01AA0003, 0, 0, '0, 0, 0);
        #1 check("tx_cnt_3", 32'(tx_cnt), 3);
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0, '0, 0, 0);
        #1 check("pndng_after_pops", 32'(pndng), 0);
        check("no_err_pop", 32'(err_pop), 0);

        // RX filtering.
        step(0, '0, 0, 1, 32'h02000055, 0, 0);
        step(0, '0, 0, 1, 32'hFF000066, 0, 0);
        step(0, '0, 0, 1, 32'h03000077, 0, 0);
        #1 check("rx_cnt_2", 32'(rx_cnt), 2);
        check("drop_1", 32'(drop_cnt), 1);
        check("rx_head", rx_data, 32'h02000055);
        step(0, '0, 0, 0, '0, 1, 0);
        step(0, '0, 0, 0, '0, 1, 0);

        // RX full: overflow, then push with simultaneous read.
        for (int i = 0; i < DEPTH; i++) step(0, '0, 0, 1, 32'h02000100 + i, 0, 0);
        step(0, '0, 0, 1, 32'h020001FF, 0, 0);
        #1 check("ovf_1", 32'(ovf_cnt), 1);
        check("rx_cnt_full", 32'(rx_cnt), DEPTH);
        step(0, '0, 0, 1, 32'hFF0001EE, 1, 0);
        #1 check("rx_cnt_full_rd", 32'(rx_cnt), DEPTH);
        check("ovf_still_1", 32'(ovf_cnt), 1);
        for (int i = 0; i < DEPTH; i++) step(0, '0, 0, 0, '0, 1, 0);

        // TX full: write with pop, drain, then pop on empty.
        for (int i = 0; i < DEPTH; i++) step(1, 32'h01000000 + i, 0, 0, '0, 0, 0);
        #1 check("tx_full_16", 32'(tx_full), 1);
        step(1, 32'h01000099, 1, 0, '0, 0, 0);
        #1 check("tx_cnt_16", 32'(tx_cnt), DEPTH);
        for (int i = 0; i < DEPTH - 1; i++) step(0, '0, 1, 0, '0, 0, 0);
        #1 check("last_head", D_pop, 32'h01000099);
        step(0, '0, 1, 0, '0, 0, 0);
        step(0, '0, 1, 0, '0, 0, 0);
        #1 check("err_pop_pulse", 32'(err_pop), 1);
        check("tx_cnt_0", 32'(tx_cnt), 0);
        idle(1);
        #1 check("err_pop_cleared", 32'(err_pop), 0);

        // Mid-stream reset with strobes high.
        for (int i = 0; i < 5; i++) step(1, 32'h05000000 + i, 0, i < 4, 32'h02000200 + i, 0, 0);
        step(1, 32'h050000AA, 0, 1, 32'h030000BB, 0, 0);
        step(1, 32'h050000CC, 1, 1, 32'h020000DD, 1, 1);
        #1 check("rst_mid_tx_cnt", 32'(tx_cnt), 0);
        check("rst_mid_rx_cnt", 32'(rx_cnt), 0);
        check("rst_mid_drop", 32'(drop_cnt), 0);
        check("rst_mid_pndng", 32'(pndng), 0);
        idle(1);

        // Randomized traffic with phase-varying pressure.
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                pw = $urandom_range(10, 90);
                pp = $urandom_range(10, 90);
                ps = $urandom_range(10, 90);
                pr = $urandom_range(10, 90);
            end
            case ($urandom_range(0, 3))
                0, 1:    d = ID;
                2:       d = 8'hFF;
                default: d = 8'($urandom);
            endcase
            step($urandom_range(0, 99) < pw, $urandom, $urandom_range(0, 99) < pp,
                 $urandom_range(0, 99) < ps, {d, 24'($urandom)},
                 $urandom_range(0, 99) < pr, $urandom_range(0, 499) == 0);
        end
        idle(1);
        @(negedge clk);
        #3;
        check("pop_exp_drained", 32'(pop_exp.size()), 0);
        check("rd_exp_drained",  32'(rd_exp.size()),  0);
        check("state_q_drained", 32'(state_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
